// File: rtl/sevled_pkg.sv
// -----------------------------------------------------------------------------
// sevled_pkg
// Shared definitions for the seven-LED code sequencer.
//   CODE_W            width of the symbol code handed to the decoder
//   NUM_CODES_DEFAULT default number of legal codes
//   seq_state_t       sequencer FSM state encoding
//   next_code()       one-step advance with explicit wrap in both directions
// -----------------------------------------------------------------------------
package sevled_pkg;

   localparam int CODE_W            = 4;
   localparam int NUM_CODES_DEFAULT = 7;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } seq_state_t;

   // Advance a code by one in the requested direction. num is one bit wider
   // than the code so that 16 legal codes can be expressed. Wrapping is done
   // with explicit compares; an out-of-range code (e.g. after an upset) is
   // pulled back into range in either direction.
   function automatic logic [CODE_W-1:0] next_code(
      input logic [CODE_W-1:0] code,
      input logic              dir,
      input logic [CODE_W:0]   num
   );
      logic [CODE_W:0]   last_s;
      logic [CODE_W-1:0] res_s;
      last_s = num - 5'd1;
      if (dir == 1'b0) begin
         if ({1'b0, code} >= last_s) begin
            res_s = 4'd0;
         end else begin
            res_s = code + 4'd1;
         end
      end else begin
         if ((code == 4'd0) || ({1'b0, code} > last_s)) begin
            res_s = last_s[CODE_W-1:0];
         end else begin
            res_s = code - 4'd1;
         end
      end
      return res_s;
   endfunction

endpackage

// File: rtl/sevled_code_sequencer_if.sv
// -----------------------------------------------------------------------------
// sevled_code_sequencer_if
// Control and status bundle of the code sequencer.
//   i_run      level, 1 = automatic stepping
//   i_step     asynchronous step request (button level)
//   i_dir      step direction, 0 = up, 1 = down
//   o_code     current symbol code for the decoder
//   o_tick     one-cycle pulse following a code change
//   o_running  high while the sequencer is auto-stepping
// Modports: master drives the controls, slave is the sequencer.
// -----------------------------------------------------------------------------
interface sevled_code_sequencer_if import sevled_pkg::*; ();

   logic              i_run;
   logic              i_step;
   logic              i_dir;
   logic [CODE_W-1:0] o_code;
   logic              o_tick;
   logic              o_running;

   modport master (
      output i_run,
      output i_step,
      output i_dir,
      input  o_code,
      input  o_tick,
      input  o_running
   );

   modport slave (
      input  i_run,
      input  i_step,
      input  i_dir,
      output o_code,
      output o_tick,
      output o_running
   );

endinterface

// File: rtl/sevled_step_sync.sv
// -----------------------------------------------------------------------------
// sevled_step_sync
// Brings an asynchronous step request into the clock domain and turns a held
// level into a single-cycle rising-edge pulse.
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   step       asynchronous step level
//   step_edge  one-cycle pulse, high while s2 is set and s3 is not yet set
// -----------------------------------------------------------------------------
module sevled_step_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic step,
   output logic step_edge
);

   logic s1_r;
   logic s2_r;
   logic s3_r;

   // Two-flop synchronizer followed by a history flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_r <= 1'b0;
         s2_r <= 1'b0;
         s3_r <= 1'b0;
      end else begin
         s1_r <= step;
         s2_r <= s1_r;
         s3_r <= s2_r;
      end
   end

   assign step_edge = s2_r & ~s3_r;

endmodule

// File: rtl/sevled_code_sequencer.sv
// -----------------------------------------------------------------------------
// sevled_code_sequencer
// Produces the symbol code for the seven-LED decoder, stepping through
// 0..NUM_CODES-1 either automatically every CLK_DIV cycles (RUN) or once per
// step request (IDLE).
//   i_clk     system clock
//   i_rst_n   asynchronous active-low reset
//   bus       sevled_code_sequencer_if.slave: run/step/dir in,
//             code/tick/running out (all outputs registered)
// Parameters:
//   CLK_DIV   cycles per automatic step, 2..2^24
//   NUM_CODES number of legal codes, 2..16
// -----------------------------------------------------------------------------
module sevled_code_sequencer import sevled_pkg::*; #(
   parameter int CLK_DIV   = 12000000,
   parameter int NUM_CODES = NUM_CODES_DEFAULT
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   sevled_code_sequencer_if.slave   bus
);

   localparam int                PRE_W    = $clog2(CLK_DIV);
   localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_DIV - 1);
   localparam logic [PRE_W-1:0]  PRE_ONE  = PRE_W'(1);
   localparam logic [CODE_W:0]   NUM_V    = (CODE_W + 1)'(NUM_CODES);

   logic              step_edge_s;
   logic              terminal_s;
   logic              adv_s;
   seq_state_t        state_r;
   logic [PRE_W-1:0]  pre_r;
   logic [CODE_W-1:0] code_r;
   logic              adv_r;
   logic              tick_r;
   logic              running_r;

   sevled_step_sync u_step_sync (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .step      (bus.i_step),
      .step_edge (step_edge_s)
   );

   // Decide whether the code advances on the coming edge. In IDLE a start
   // request has priority, so a coincident step edge is dropped. In RUN the
   // terminal count advances regardless of i_run falling on the same edge.
   always_comb begin
      adv_s      = 1'b0;
      terminal_s = (pre_r == PRE_LAST);
      case (state_r)
         IDLE: begin
            if (!bus.i_run && step_edge_s) begin
               adv_s = 1'b1;
            end else begin
               adv_s = 1'b0;
            end
         end
         RUN: begin
            if (terminal_s) begin
               adv_s = 1'b1;
            end else begin
               adv_s = 1'b0;
            end
         end
         default: begin
            adv_s = 1'b0;
         end
      endcase
   end

   // Sequencer FSM with prescaler, code register and registered status.
   // o_tick is delayed one extra stage so it is high in the cycle after the
   // new code became visible.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r   <= IDLE;
         pre_r     <= '0;
         code_r    <= 4'd0;
         adv_r     <= 1'b0;
         tick_r    <= 1'b0;
         running_r <= 1'b0;
      end else begin
         adv_r  <= adv_s;
         tick_r <= adv_r;
         if (adv_s) begin
            code_r <= next_code(code_r, bus.i_dir, NUM_V);
         end else begin
            code_r <= code_r;
         end
         case (state_r)
            IDLE: begin
               pre_r <= '0;
               if (bus.i_run) begin
                  state_r   <= RUN;
                  running_r <= 1'b1;
               end else begin
                  state_r   <= IDLE;
                  running_r <= 1'b0;
               end
            end
            RUN: begin
               if (!bus.i_run) begin
                  state_r   <= IDLE;
                  running_r <= 1'b0;
                  pre_r     <= '0;
               end else begin
                  state_r   <= RUN;
                  running_r <= 1'b1;
                  if (terminal_s) begin
                     pre_r <= '0;
                  end else begin
                     pre_r <= pre_r + PRE_ONE;
                  end
               end
            end
            default: begin
               state_r   <= IDLE;
               running_r <= 1'b0;
               pre_r     <= '0;
            end
         endcase
      end
   end

   assign bus.o_code    = code_r;
   assign bus.o_tick    = tick_r;
   assign bus.o_running = running_r;

endmodule

// File: tb/tb_sevled_code_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sevled_code_sequencer
// Directed bench for the code sequencer with CLK_DIV=4 and NUM_CODES=7.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_sevled_code_sequencer;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   tick_cnt;
   int   t0;

   sevled_code_sequencer_if bus_if ();

   sevled_code_sequencer #(
      .CLK_DIV   (4),
      .NUM_CODES (7)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count tick pulses as seen at each rising edge.
   always_ff @(posedge clk) begin
      if (bus_if.o_tick === 1'b1) begin
         tick_cnt <= tick_cnt + 1;
      end
   end

   // Absolute time limit so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout reached before summary");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One manual press held 10 cycles: code must change on the 3rd edge,
   // tick one cycle later for one cycle, and the held level must not repeat.
   task automatic press(input string tag, input logic [3:0] prev, input logic [3:0] exp);
      bus_if.i_step = 1'b1;
      cyc(2);
      chk({tag, "_before"}, 8'(bus_if.o_code), 8'(prev));
      cyc(1);
      chk({tag, "_code"}, 8'(bus_if.o_code), 8'(exp));
      chk({tag, "_tick_early"}, 8'(bus_if.o_tick), 8'd0);
      cyc(1);
      chk({tag, "_tick"}, 8'(bus_if.o_tick), 8'd1);
      cyc(1);
      chk({tag, "_tick_end"}, 8'(bus_if.o_tick), 8'd0);
      cyc(5);
      chk({tag, "_hold"}, 8'(bus_if.o_code), 8'(exp));
      bus_if.i_step = 1'b0;
      cyc(4);
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      tick_cnt      = 0;
      rst_n         = 1'b0;
      bus_if.i_run  = 1'b0;
      bus_if.i_step = 1'b0;
      bus_if.i_dir  = 1'b0;

      // Reset state
      cyc(3);
      chk("rst_code", 8'(bus_if.o_code), 8'd0);
      chk("rst_tick", 8'(bus_if.o_tick), 8'd0);
      chk("rst_running", 8'(bus_if.o_running), 8'd0);
      rst_n = 1'b1;
      cyc(2);
      chk("idle_code", 8'(bus_if.o_code), 8'd0);

      // Manual up through the wrap: 1,2,3,4,5,6,0
      t0 = tick_cnt;
      for (int i = 1; i <= 7; i++) begin
         press("up", 4'(i - 1), 4'(i % 7));
      end
      chk("up_tick_count", 8'(tick_cnt - t0), 8'd7);

      // Manual down wrap 0 -> 6
      bus_if.i_dir = 1'b1;
      t0 = tick_cnt;
      press("down", 4'd0, 4'd6);
      chk("down_tick_count", 8'(tick_cnt - t0), 8'd1);

      // Move to code 2
      bus_if.i_dir = 1'b0;
      press("prep_a", 4'd6, 4'd0);
      press("prep_b", 4'd0, 4'd1);
      press("prep_c", 4'd1, 4'd2);

      // Auto run from code 2
      bus_if.i_run = 1'b1;
      cyc(1);
      chk("run_entry_running", 8'(bus_if.o_running), 8'd1);
      chk("run_entry_code", 8'(bus_if.o_code), 8'd2);
      cyc(3);
      chk("run_before_first", 8'(bus_if.o_code), 8'd2);
      cyc(1);
      chk("run_first", 8'(bus_if.o_code), 8'd3);
      bus_if.i_step = 1'b1;
      cyc(3);
      chk("run_step_ignored", 8'(bus_if.o_code), 8'd3);
      cyc(1);
      chk("run_second", 8'(bus_if.o_code), 8'd4);
      bus_if.i_step = 1'b0;
      cyc(4);
      chk("run_third", 8'(bus_if.o_code), 8'd5);

      // Drop run on the terminal-count edge
      cyc(3);
      chk("stop_pre_code", 8'(bus_if.o_code), 8'd5);
      bus_if.i_run = 1'b0;
      cyc(1);
      chk("stop_code", 8'(bus_if.o_code), 8'd6);
      chk("stop_running", 8'(bus_if.o_running), 8'd0);
      cyc(10);
      chk("stop_hold", 8'(bus_if.o_code), 8'd6);
      chk("stop_hold_running", 8'(bus_if.o_running), 8'd0);

      // Re-enter RUN: prescaler restarts from 0
      bus_if.i_run = 1'b1;
      cyc(1);
      chk("reentry_running", 8'(bus_if.o_running), 8'd1);
      cyc(3);
      chk("reentry_before", 8'(bus_if.o_code), 8'd6);
      cyc(1);
      chk("reentry_advance", 8'(bus_if.o_code), 8'd0);
      bus_if.i_run = 1'b0;
      cyc(1);
      chk("reentry_exit", 8'(bus_if.o_running), 8'd0);

      // Simultaneous start and step edge in IDLE with code 1
      cyc(2);
      press("sim_prep", 4'd0, 4'd1);
      bus_if.i_step = 1'b1;
      cyc(2);
      bus_if.i_run = 1'b1;
      cyc(1);
      chk("sim_code", 8'(bus_if.o_code), 8'd1);
      chk("sim_running", 8'(bus_if.o_running), 8'd1);
      cyc(3);
      chk("sim_before_first", 8'(bus_if.o_code), 8'd1);
      cyc(1);
      chk("sim_first", 8'(bus_if.o_code), 8'd2);
      bus_if.i_step = 1'b0;
      cyc(12);
      chk("midrun_code", 8'(bus_if.o_code), 8'd5);

      // Asynchronous reset mid-run, checked before the next clock edge
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_code", 8'(bus_if.o_code), 8'd0);
      chk("async_rst_tick", 8'(bus_if.o_tick), 8'd0);
      chk("async_rst_running", 8'(bus_if.o_running), 8'd0);
      bus_if.i_run = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(3);
      chk("post_rst_code", 8'(bus_if.o_code), 8'd0);
      chk("post_rst_running", 8'(bus_if.o_running), 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
